button_debounce_scheduler: RTL and testbench

- Debounces N raw push-buttons with one shared settle timer instead of one counter per button.
- Buttons with a pending level change are served one at a time in round-robin order.
- Per-button debounced levels and 1-cycle rising/falling edge pulses drive the LED-matrix mode/colour logic.
- Sits between the board button pins and the matrix control FSMs.

---
 rtl/button_pkg.sv | 11 +
 rtl/btn_rr_picker.sv | 32 +++
 rtl/button_debounce_scheduler.sv | 100 ++++++++++
 tb/tb_button_debounce_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared FSM states, default settle time and width helpers for the button debouncer.
package button_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
  localparam int DEFAULT_SETTLE_CYC = 1048576;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_rr_picker.sv
// btn_rr_picker: combinational round-robin select of the first pending button after ptr.
module btn_rr_picker #(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_BTN-1:0] pending,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic             hi_any, lo_any;
  logic [IDX_W-1:0] hi_idx, lo_idx;
  // Scan downwards so the lowest index in each half wins; indices above ptr come first.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i] && IDX_W'(i) > ptr) begin
        hi_any = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (pending[i] && IDX_W'(i) <= ptr) begin
        lo_any = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
    any = hi_any | lo_any;
    idx = hi_any ? hi_idx : lo_idx;
  end
endmodule

// File: rtl/button_debounce_scheduler.sv
// button_debounce_scheduler: debounces N buttons with one shared settle timer, served round-robin.
module button_debounce_scheduler
  import button_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int SETTLE_CYC = DEFAULT_SETTLE_CYC,
  parameter int CNT_W      = cnt_w(SETTLE_CYC),
  parameter int IDX_W      = idx_w(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] r_edge,
  output logic [N_BTN-1:0] f_edge,
  output logic             busy,
  output logic [IDX_W-1:0] active_idx
);
  state_t           state, state_n;
  logic [N_BTN-1:0] sync0, sync1, btn_n, r_n, f_n;
  logic [IDX_W-1:0] sel, sel_n, ptr, ptr_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lvl, lvl_n, any;

  btn_rr_picker #(.N_BTN(N_BTN), .IDX_W(IDX_W)) u_pick (
    .pending(sync1 ^ btn_state),
    .ptr    (ptr),
    .any    (any),
    .idx    (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0     <= '0;
      sync1     <= '0;
      btn_state <= '0;
      r_edge    <= '0;
      f_edge    <= '0;
      state     <= IDLE;
      sel       <= '0;
      ptr       <= IDX_W'(N_BTN - 1);
      cnt       <= '0;
      lvl       <= 1'b0;
    end else begin
      sync0     <= buttons;
      sync1     <= sync0;
      btn_state <= btn_n;
      r_edge    <= r_n;
      f_edge    <= f_n;
      state     <= state_n;
      sel       <= sel_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      lvl       <= lvl_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    lvl_n   = lvl;
    btn_n   = btn_state;
    r_n     = '0;
    f_n     = '0;
    case (state)
      IDLE: if (any) begin
        state_n = SETTLE;
        sel_n   = pick;
        lvl_n   = sync1[pick];
        cnt_n   = '0;
      end
      // A bounce restarts the window; bouncing back to the accepted level abandons it.
      SETTLE: if (sync1[sel] != lvl) begin
        cnt_n = '0;
        lvl_n = sync1[sel];
        if (sync1[sel] == btn_state[sel]) begin
          ptr_n   = sel;
          state_n = IDLE;
        end
      end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
        state_n = COMMIT;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      COMMIT: begin
        btn_n[sel] = lvl;
        r_n[sel]   = lvl;
        f_n[sel]   = ~lvl;
        ptr_n      = sel;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = state != IDLE;
  assign active_idx = sel;
endmodule

// File: tb/tb_button_debounce_scheduler.sv
// tb_button_debounce_scheduler: vector table, corner sequences and random run against a timestamp model.
module tb_button_debounce_scheduler;
  localparam int S4 = 8;
  logic       clk = 1'b0;
  logic       rst4 = 1'b1, rst2 = 1'b1;
  logic [3:0] btn4 = '0, st4, r4, f4;
  logic [1:0] btn2 = '0, st2, r2, f2, idx4;
  logic       idx2, busy4, busy2;
  int total = 0, bad = 0;

  button_debounce_scheduler #(.N_BTN(4), .SETTLE_CYC(S4)) u4 (
    .clk(clk), .rst(rst4), .buttons(btn4), .btn_state(st4), .r_edge(r4),
    .f_edge(f4), .busy(busy4), .active_idx(idx4)
  );
  button_debounce_scheduler #(.N_BTN(2), .SETTLE_CYC(4)) u2 (
    .clk(clk), .rst(rst2), .buttons(btn2), .btn_state(st2), .r_edge(r2),
    .f_edge(f2), .busy(busy2), .active_idx(idx2)
  );

  always #5 clk = ~clk;

  // Reference: the settle window is tracked as a start timestamp rather than a counter.
  logic [3:0] m_s0 = '0, m_s1 = '0, m_st = '0, m_re = '0, m_fe = '0;
  logic [1:0] m_sel = '0, m_ptr = 2'd3;
  logic       m_lvl = 1'b0;
  int         m_mode = 0, m_t0 = 0, now = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    now++;
    if (rst4) begin
      m_s0 = '0; m_s1 = '0; m_st = '0; m_re = '0; m_fe = '0;
      m_mode = 0; m_sel = '0; m_lvl = 1'b0; m_ptr = 2'd3; m_t0 = now;
    end else begin
      m_re = '0;
      m_fe = '0;
      found = 1'b0;
      if (m_mode == 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && m_s1[(int'(m_ptr) + k) % 4] != m_st[(int'(m_ptr) + k) % 4]) begin
            found = 1'b1;
            m_sel = 2'((int'(m_ptr) + k) % 4);
          end
        end
        if (found) begin
          m_lvl = m_s1[m_sel];
          m_t0 = now;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (m_s1[m_sel] != m_lvl) begin
          m_lvl = m_s1[m_sel];
          m_t0 = now;
          if (m_lvl == m_st[m_sel]) begin
            m_mode = 0;
            m_ptr = m_sel;
          end
        end else if (now - m_t0 == S4) m_mode = 2;
      end else begin
        m_st[m_sel] = m_lvl;
        if (m_lvl) m_re[m_sel] = 1'b1;
        else m_fe[m_sel] = 1'b1;
        m_ptr = m_sel;
        m_mode = 0;
      end
      m_s1 = m_s0;
      m_s0 = btn4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {st4, r4, f4, busy4, idx4}, {m_st, m_re, m_fe, m_mode != 0, m_sel});
  endtask

  typedef struct {
    int         n;
    logic [3:0] btn, st, re, fe;
    logic       busy;
    logic [1:0] idx;
  } vec_t;
  vec_t tbl[13];
  int sim_e[3] = '{11, 21, 31};
  int sim_v[3] = '{1, 2, 8};
  int n, m;

  initial begin
    tbl[0]  = '{2,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
    tbl[2]  = '{8,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
    tbl[3]  = '{1,  4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{1,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[5]  = '{2,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{9,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2};
    tbl[7]  = '{1,  4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0};
    tbl[8]  = '{1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[9]  = '{3,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
    tbl[10] = '{2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
    tbl[11] = '{1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tick();
    tick();
    chk("reset4", {st4, r4, f4, busy4, idx4}, 15'd0);
    chk("reset2", {st2, r2, f2, busy2, idx2}, 7'd0);
    rst4 = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 13; i++) begin
      btn4 = tbl[i].btn;
      for (int j = 0; j < tbl[i].n; j++) tick();
      chk($sformatf("vec%0d", i), {st4, r4, f4, busy4, busy4 ? idx4 : 2'd0},
          {tbl[i].st, tbl[i].re, tbl[i].fe, tbl[i].busy, tbl[i].idx});
    end
    n = 0; m = 0;
    for (int e = 0; e < 30; e++) begin
      btn4 = (e < 3 || e >= 5) ? 4'b0001 : 4'b0000;
      tick();
      if (|r4) begin
        chk("bounce_r", (e << 4) | int'(r4), (16 << 4) | 1);
        n++;
      end
      if (|f4) m++;
    end
    chk("bounce_r_cnt", n, 1);
    chk("bounce_no_f", m, 0);
    rst4 = 1'b1;
    btn4 = '0;
    tick();
    tick();
    rst4 = 1'b0;
    n = 0;
    for (int e = 0; e < 45; e++) begin
      btn4 = 4'b1011;
      tick();
      if (|r4) begin
        chk($sformatf("sim_r%0d", n), (e << 4) | int'(r4), n < 3 ? (sim_e[n] << 4) | sim_v[n] : 0);
        n++;
      end
    end
    chk("sim_r_cnt", n, 3);
    n = 0; m = 0;
    for (int e = 0; e < 35; e++) begin
      btn4 = 4'b0010;
      tick();
      if (|f4) begin
        chk($sformatf("rel_f%0d", n), (e << 4) | int'(f4), n == 0 ? (11 << 4) | 1 : (21 << 4) | 8);
        n++;
      end
      if (|r4) m++;
    end
    chk("rel_f_cnt", n, 2);
    chk("rel_no_r", m, 0);
    rst4 = 1'b1;
    btn4 = '0;
    tick();
    tick();
    rst4 = 1'b0;
    n = 0;
    // Reset sampled at edge 6 clears the synchronisers, so the first fresh sample is edge 7.
    for (int e = 0; e < 40; e++) begin
      rst4 = e == 6;
      btn4 = e < 6 ? 4'b0100 : 4'b0101;
      tick();
      if (e == 3) chk("mid_busy", {busy4, idx4}, 3'b110);
      if (e == 6) chk("mid_reset", {st4, r4, f4, busy4, idx4}, 15'd0);
      if (|r4) begin
        chk($sformatf("rst_r%0d", n), (e << 4) | int'(r4), n == 0 ? (18 << 4) | 1 : (28 << 4) | 4);
        n++;
      end
    end
    chk("rst_r_cnt", n, 2);
    n = 0; m = 0;
    for (int e = 0; e < 15; e++) begin
      btn2 = 2'b10;
      tick();
      if (|r2) begin
        chk("n2_r", (e << 4) | int'(r2), (7 << 4) | 2);
        n++;
      end
      if (|f2) m++;
    end
    chk("n2_press", {st2, 2'(n), 2'(m)}, {2'b10, 2'd1, 2'd0});
    for (int e = 0; e < 15; e++) begin
      btn2 = 2'b00;
      tick();
      if (|f2) begin
        chk("n2_f", (e << 4) | int'(f2), (7 << 4) | 2);
        m++;
      end
      if (|r2) n++;
    end
    chk("n2_release", {st2, 2'(n), 2'(m)}, {2'b00, 2'd1, 2'd1});
    for (int c = 0; c < 4000; c++) begin
      m = ((c / 400) % 2) != 0 ? 40 : 4;
      rst4 = $urandom_range(0, 799) == 0;
      if ($urandom_range(0, m - 1) == 0) btn4 = btn4 ^ (4'b0001 << $urandom_range(0, 3));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
